// File: rtl/ecg_sample_feeder_pkg.sv
// Shared widths, FSM encoding, error bit positions and output saturation
// helper for the ECG sample feeder.
package ecg_pkg;
  localparam int SAMPLE_W        = 9;
  localparam int ADC_W           = 12;
  localparam int MIN_GAP_DEFAULT = 128;
  localparam int ERR_OVERRUN     = 0;
  localparam int ERR_TIMEOUT     = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CONV = 2'd1,
    COMPUTE   = 2'd2
  } state_t;

  function automatic sample_t sat_sample(input logic signed [12:0] v);
    if (v > 13'sd255) return sample_t'(9'sd255);
    if (v < -13'sd256) return sample_t'(-9'sd256);
    return sample_t'(v[SAMPLE_W-1:0]);
  endfunction
endpackage

// File: rtl/ecg_sample_feeder_conv_tick_gen.sv
// Free-running conversion pacer: down-counter reloaded on terminal count,
// giving a one-cycle tick every TICK_DIV clocks.
module conv_tick_gen #(
  parameter int TICK_DIV = 162500
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || tick) count <= CW'(TICK_DIV - 1);
    else               count <= count - CW'(1);
  end

  assign tick = (count == '0);
endmodule

// File: rtl/ecg_sample_feeder.sv
// ECG front end: paces ADC conversions, boxcar-decimates, removes the DC midpoint
// and emits gap-limited 9-bit samples. DC_TRACK_EN selects a tracking baseline.
//
// state     | meaning
// IDLE      | waiting for the next conversion tick
// WAIT_CONV | conv_start issued, waiting for adc_valid or timeout
// COMPUTE   | two-cycle mean/offset then shift/saturate pipeline
module ecg_sample_feeder
  import ecg_pkg::*;
#(
  parameter int TICK_DIV     = 162500,
  parameter int DECIM_LOG2   = 2,
  parameter int MIN_GAP      = MIN_GAP_DEFAULT,
  parameter int CONV_TIMEOUT = 1024,
  parameter int ADC_MID      = 2048
) (
  input  logic        clock,
  input  logic        reset,
  output logic        conv_start,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  input  logic        clear_err,
  output logic        ready,
  output logic [8:0]  x,
  output logic [1:0]  err,
  output logic        busy
);
  localparam int ACC_W = ADC_W + DECIM_LOG2;
  localparam int CNT_W = DECIM_LOG2 + 1;
  localparam int TMO_W = $clog2(CONV_TIMEOUT + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  state_t             state_q, state_d;
  logic               tick, start, skip, take, timeout, last, load, emit, gap_ok;
  logic               phase_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic [ADC_W-1:0]   mean;
  logic signed [12:0] d_next, d_q;
  sample_t            pend_q, x_q;
  logic               pend_valid_q, ready_q, conv_start_q;
  logic [GAP_W-1:0]   gap_q;
  logic [1:0]         err_q, err_set;

  conv_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign last    = (cnt_inc == CNT_W'(1 << DECIM_LOG2));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (tick) state_d = WAIT_CONV;
      WAIT_CONV: begin
        if (adc_valid)           state_d = last ? COMPUTE : IDLE;
        else if (tmo_q == '0)    state_d = IDLE;
      end
      COMPUTE: if (phase_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    skip    = 1'b0;
    take    = 1'b0;
    timeout = 1'b0;
    load    = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy  = 1'b0;
        start = tick;
      end
      WAIT_CONV: begin
        skip    = tick;
        take    = adc_valid;
        timeout = !adc_valid && (tmo_q == '0);
      end
      COMPUTE: begin
        skip = tick;
        load = phase_q;
      end
      default: busy = 1'b0;
    endcase
  end

  assign mean = acc_q[ACC_W-1:DECIM_LOG2];

`ifdef DC_TRACK_EN
  // Baseline is 12.4 fixed point; d uses the value from before this update.
  logic [15:0]        base_q;
  logic signed [17:0] base_diff;

  assign d_next    = $signed({1'b0, mean}) - $signed({1'b0, base_q[15:4]});
  assign base_diff = $signed({2'b00, mean, 4'b0000}) - $signed({2'b00, base_q});

  always_ff @(posedge clock) begin
    if (reset)                               base_q <= 16'(ADC_MID << 4);
    else if (state_q == COMPUTE && !phase_q) base_q <= base_q + 16'(base_diff >>> 6);
  end
`else
  assign d_next = $signed({1'b0, mean}) - $signed(13'(ADC_MID));
`endif

  assign gap_ok = (gap_q == GAP_W'(MIN_GAP - 1));
  assign emit   = pend_valid_q && gap_ok;

  // A result landing in the same cycle the old one leaves is not an overrun.
  assign err_set[ERR_OVERRUN] = skip || (load && pend_valid_q && !emit);
  assign err_set[ERR_TIMEOUT] = timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      conv_start_q <= 1'b0;
      phase_q      <= 1'b0;
      tmo_q        <= TMO_W'(CONV_TIMEOUT - 1);
      acc_q        <= '0;
      cnt_q        <= '0;
      d_q          <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      gap_q        <= '0;
      ready_q      <= 1'b0;
      x_q          <= '0;
      err_q        <= '0;
    end else begin
      conv_start_q <= start;
      phase_q      <= (state_q == COMPUTE) && !phase_q;
      tmo_q        <= (state_q == WAIT_CONV) ? tmo_q - TMO_W'(1) : TMO_W'(CONV_TIMEOUT - 1);
      if (take) begin
        acc_q <= acc_q + ACC_W'(adc_data);
        cnt_q <= cnt_inc;
      end else if (load) begin
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == COMPUTE && !phase_q) d_q <= d_next;
      if (load) begin
        pend_q       <= sat_sample(d_q >>> 3);
        pend_valid_q <= 1'b1;
      end else if (emit) begin
        pend_valid_q <= 1'b0;
      end
      if (emit)         gap_q <= '0;
      else if (!gap_ok) gap_q <= gap_q + GAP_W'(1);
      ready_q <= emit;
      if (emit) x_q <= pend_q;
      err_q <= (err_q & ~{2{clear_err}}) | err_set;
    end
  end

  assign conv_start = conv_start_q;
  assign ready      = ready_q;
  assign x          = x_q;
  assign err        = err_q;
endmodule

// File: tb/tb_ecg_sample_feeder.sv
// Bench for ecg_sample_feeder: lane 0 (TICK_DIV=200, 4x decimation) runs directed
// scenarios, lane 1 (TICK_DIV=20, no decimation) exercises overrun and gap limiting.
module tb_ecg_sample_feeder;
  localparam int MIN_GAP = 128;

  typedef struct {
    int a;
    int val;
  } comp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       rst       [2] = '{1'b1, 1'b1};
  logic       rst_s     [2] = '{1'b0, 1'b0};
  logic       clr       [2] = '{1'b0, 1'b0};
  logic       adc_valid [2] = '{1'b0, 1'b0};
  logic [11:0] adc_data [2] = '{12'd0, 12'd0};
  logic       conv_start[2];
  logic       ready     [2];
  logic       busy      [2];
  logic [8:0] x         [2];
  logic [1:0] err       [2];

  int withhold  [2] = '{0, 0};
  int ready_cnt [2] = '{0, 0};
  int ready_edge[2] = '{0, 0};
  int final_v   [2] = '{0, 0};
  int conv_cnt  [2] = '{0, 0};
  int min_space [2] = '{1000000, 1000000};
  int overwrites[2] = '{0, 0};
  int data_q0[$];

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int TD = (g == 0) ? 200 : 20;
    localparam int DL = (g == 0) ? 2 : 0;
    comp_t compq[$];

    ecg_sample_feeder #(
      .TICK_DIV(TD), .DECIM_LOG2(DL), .MIN_GAP(MIN_GAP), .CONV_TIMEOUT(64), .ADC_MID(2048)
    ) dut (
      .clock(clock), .reset(rst[g]), .conv_start(conv_start[g]), .adc_valid(adc_valid[g]),
      .adc_data(adc_data[g]), .clear_err(clr[g]), .ready(ready[g]), .x(x[g]),
      .err(err[g]), .busy(busy[g])
    );

    always @(posedge clock) rst_s[g] <= rst[g];

    // Model: each completed average becomes available 3 edges after its final
    // adc_valid; it is emitted no earlier than MIN_GAP edges after the previous
    // ready (or reset), and a newer result replaces an unemitted one.
    initial begin : model
      int  cd, acc, n, pend, pval, rtime, last_r, exp_x, gen, d, v;
      bit  armed, exp_r;
      cd = 0; acc = 0; n = 0; pend = 0; pval = 0; rtime = 0; last_r = 0;
      exp_x = 0; gen = 0; d = 0; v = 0; armed = 1'b0; exp_r = 1'b0;
      forever begin
        @(negedge clock);
        adc_valid[g] = 1'b0;
        if (rst_s[g]) begin
          armed = 1'b1; cd = 0; acc = 0; n = 0; pend = 0; exp_x = 0; last_r = cyc;
          compq.delete();
          check("rst_ready", int'(ready[g]), 0);
          check("rst_x", int'($signed(x[g])), 0);
        end else if (armed) begin
          if (compq.size() > 0 && compq[0].a == cyc) begin
            if (pend != 0) overwrites[g]++;
            pend  = 1;
            pval  = compq[0].val;
            void'(compq.pop_front());
            rtime = (cyc > last_r + MIN_GAP) ? cyc : last_r + MIN_GAP;
          end
          exp_r = (pend != 0) && (cyc == rtime);
          if (exp_r) begin
            exp_x  = pval;
            pend   = 0;
            last_r = cyc;
          end
          check("ready", int'(ready[g]), int'(exp_r));
          check("x", int'($signed(x[g])), exp_x);
          if (ready[g]) begin
            if (ready_cnt[g] > 0 && cyc - ready_edge[g] < min_space[g])
              min_space[g] = cyc - ready_edge[g];
            ready_cnt[g]++;
            ready_edge[g] = cyc;
          end
          if (cd > 0) begin
            cd--;
            if (cd == 0) begin
              if (withhold[g] > 0) begin
                withhold[g]--;
              end else begin
                if (g == 1) begin
                  d = (1000 + 37 * gen) % 4096;
                  gen++;
                end else if (data_q0.size() > 0) begin
                  d = data_q0.pop_front();
                end else begin
                  d = 2048;
                end
                adc_valid[g] = 1'b1;
                adc_data[g]  = 12'(d);
                conv_cnt[g]++;
                acc += d;
                n++;
                if (n == (1 << DL)) begin
                  v = ((acc >> DL) - 2048) >>> 3;
                  if (v > 255) v = 255;
                  if (v < -256) v = -256;
                  compq.push_back('{cyc + 4, v});
                  final_v[g] = cyc + 1;
                  acc = 0;
                  n = 0;
                end
              end
            end
          end
          if (conv_start[g]) cd = 9;
        end
      end
    end
  end

  task automatic wait_ready0(input string name);
    int start_cnt;
    int t;
    start_cnt = ready_cnt[0];
    t = 0;
    while (ready_cnt[0] == start_cnt && t < 3000) begin
      @(negedge clock);
      t++;
    end
    total++;
    if (ready_cnt[0] == start_cnt) begin
      bad++;
      $display("FAIL %s: got no ready expected one within 3000 cycles", name);
    end
  endtask

  task automatic push0(input int val, input int count);
    for (int i = 0; i < count; i++) data_q0.push_back(val);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish expected done by 2ms");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0, c0, t;
    repeat (3) @(negedge clock);
    check("rst_conv_start", int'(conv_start[0]), 0);
    check("rst_ready0", int'(ready[0]), 0);
    check("rst_x0", int'(x[0]), 0);
    check("rst_err", int'(err[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    push0(2048, 8);
    wait_ready0("mid_ready1");
    r0 = ready_edge[0];
    check("mid_x1", int'($signed(x[0])), 0);
    wait_ready0("mid_ready2");
    check("mid_spacing", ready_edge[0] - r0, 800);
    check("mid_x2", int'($signed(x[0])), 0);
    check("mid_err", int'(err[0]), 0);

    push0(4095, 4);
    wait_ready0("max_ready");
    check("max_x", int'($signed(x[0])), 255);
    push0(0, 4);
    wait_ready0("min_ready");
    check("min_x", int'($signed(x[0])), -256);

    data_q0.push_back(2048);
    data_q0.push_back(2056);
    data_q0.push_back(2064);
    data_q0.push_back(2072);
    wait_ready0("ramp_ready");
    check("ramp_x", int'($signed(x[0])), 1);
    check("ramp_latency", ready_edge[0] - final_v[0], 3);

    withhold[0] = 1;
    push0(2100, 4);
    r0 = ready_cnt[0];
    t = 0;
    while (!err[0][1] && t < 1000) begin
      @(negedge clock);
      t++;
    end
    check("tmo_err", int'(err[0]), 2);
    check("tmo_no_ready", ready_cnt[0] - r0, 0);
    wait_ready0("tmo_ready");
    check("tmo_x", int'($signed(x[0])), 6);
    check("tmo_err_sticky", int'(err[0]), 2);
    clr[0] = 1'b1;
    @(negedge clock);
    clr[0] = 1'b0;
    @(negedge clock);
    check("clear_err", int'(err[0]), 0);

    c0 = conv_cnt[0];
    push0(3000, 4);
    t = 0;
    while (conv_cnt[0] < c0 + 2 && t < 1500) begin
      @(negedge clock);
      t++;
    end
    check("part_convs", conv_cnt[0] - c0, 2);
    repeat (3) @(negedge clock);
    rst[0] = 1'b1;
    @(negedge clock);
    check("part_rst_ready", int'(ready[0]), 0);
    check("part_rst_x", int'(x[0]), 0);
    rst[0] = 1'b0;
    data_q0.delete();
    push0(2200, 4);
    c0 = conv_cnt[0];
    wait_ready0("part_ready");
    check("part_x", int'($signed(x[0])), 19);
    check("part_fresh_convs", conv_cnt[0] - c0, 4);

    check("fast_err", int'(err[1]), 1);
    check("fast_gap", int'(min_space[1] >= MIN_GAP), 1);
    check("fast_ready_cnt", int'(ready_cnt[1] > 10), 1);
    check("fast_overwrites", int'(overwrites[1] > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecg_sample_feeder.md
Name: ecg_sample_feeder

Overview:
Front-end producer for the ECG filter chain. Paces ADC conversions, decimates raw 12-bit unsigned readings by boxcar averaging, removes the DC midpoint and scales to 9-bit signed. Drives the ready/x sample interface consumed by the low-pass and matched FIR stages. Guarantees the minimum spacing between ready pulses that those stages require.

Parameters:
TICK_DIV, 162500, clocks per conversion request (65 MHz / 400 Hz)
DECIM_LOG2, 2, log2 of conversions averaged per output sample (4 → 100 Hz output)
MIN_GAP, 128, minimum clocks between successive ready pulses
CONV_TIMEOUT, 1024, clocks to wait for adc_valid after conv_start
ADC_MID, 2048, fixed DC midpoint subtracted from the averaged reading

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
conv_start  out  1  one-cycle conversion request to the ADC wrapper
adc_valid  in  1  one-cycle strobe, adc_data valid
adc_data  in  12  unsigned ADC reading
clear_err  in  1  clears sticky error flags
ready  out  1  one-cycle strobe, new sample on x
x  out  9  signed sample, held between ready pulses
err  out  2  sticky flags: [0] overrun, [1] conversion timeout
busy  out  1  high while in WAIT_CONV or COMPUTE

Behaviour:
- Clock is clock; reset is reset, synchronous, active-high.
- Reset values: conv_start=0, ready=0, x=0, err=0, busy=0. Accumulator, conversion count, tick counter, gap counter and pending flag are all cleared; FSM goes to IDLE.
- Reset mid-operation discards any partial accumulation. The next output requires 2^DECIM_LOG2 fresh conversions.
- Tick counter runs freely modulo TICK_DIV. On wrap: if FSM is IDLE, pulse conv_start for 1 cycle and go to WAIT_CONV. Otherwise the tick is skipped and err[0] is set.
- FSM IDLE → WAIT_CONV on tick.
- WAIT_CONV → IDLE on adc_valid. adc_data is zero-extended and added into the accumulator (width 12+DECIM_LOG2), and the count is incremented. If the count reaches 2^DECIM_LOG2, go to COMPUTE instead of IDLE.
- WAIT_CONV → IDLE after CONV_TIMEOUT clocks without adc_valid. Set err[1]; the accumulator and count are unchanged.
- adc_valid is ignored outside WAIT_CONV.
- COMPUTE takes 2 clocks:
  - Stage 1: mean = acc >> DECIM_LOG2; d = mean − ADC_MID as 13-bit signed.
  - Stage 2: s = d >>> 3 (arithmetic), saturated to [−256, 255].
  - Then clear the accumulator and count, load result into pending, set pending flag, return to IDLE.
- Emit: when pending and gap counter ≥ MIN_GAP − 1, the same cycle sets x ← pending, ready=1 (one cycle), clears pending and zeroes the gap counter. The gap counter saturates at MIN_GAP − 1.
- Latency: ready asserts 3 clocks after the edge sampling the final adc_valid, when the gap is satisfied; otherwise it is delayed until the gap is satisfied.
- If a new result completes while pending is still set, the older value is overwritten and err[0] is set.
- x changes only on ready cycles.
- err bits are sticky until clear_err or reset. If clear_err coincides with a new error event, the set wins.

Optional Feature:
DC_TRACK_EN
- Defined: the midpoint is a 16-bit running baseline (12.4 fixed point), initialised to ADC_MID<<4 at reset. Each output updates it as base += ((mean<<4) − base) >>> 6, and d = mean − (base>>4) uses the pre-update baseline.
- Undefined: the fixed ADC_MID parameter is used, and no baseline register exists.

Decomposition:
- Shared package ecg_pkg: SAMPLE_W=9, ADC_W=12, MIN_GAP_DEFAULT=128, typedef sample_t (signed [8:0]), FSM state enum (IDLE, WAIT_CONV, COMPUTE), err bit index constants.
- One sub-module, conv_tick_gen: parameterised TICK_DIV divider producing the one-cycle tick.

Test Plan:
All scenarios use TICK_DIV=200, DECIM_LOG2=2, CONV_TIMEOUT=64, and an ADC model answering 10 clocks after conv_start unless stated.
- Four conversions of 2048 → one ready, x=0; next ready ≈800 clocks later; err=0.
- Four conversions of 4095 → x=255. Four of 0 → x=−256. Saturation bounds are hit without wrap.
- Conversions 2048, 2056, 2064, 2072 → sum 8240, mean 2060, x=1; ready 3 clocks after the 4th adc_valid.
- Model withholds adc_valid for one conversion → err[1]=1 after 64 clocks, no ready. Four further good conversions → ready; clear_err → err=0.
- TICK_DIV=20, DECIM_LOG2=0 → ready spacing is always ≥128 clocks, err[0]=1, and x is always the latest completed value.
- Reset after 2 of 4 conversions → ready=0 and x=0 next cycle. The next ready appears only after 4 new conversions.
